// File: rtl/tcb_sub_mem.sv
// ---------------------------------------------------------------------------
// tcb_sub_mem
// Byte-addressed synchronous memory acting as a TCB subordinate. It accepts
// one request per cycle (no backpressure once out of reset), commits writes
// at the transfer edge and returns {read data, error status} through a fixed
// DLY-stage response pipeline so the timing matches the manager side.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, asserted low
//   tcb_vld      request valid
//   tcb_rdy      request ready (registered, 0 during reset)
//   tcb_req_wen  1 = write, 0 = read
//   tcb_req_adr  byte address
//   tcb_req_byt  write byte enables
//   tcb_req_wdt  write data
//   tcb_rsp_rdt  read data, DLY cycles after the transfer
//   tcb_rsp_sts  error status, DLY cycles after the transfer
// ---------------------------------------------------------------------------
module tcb_sub_mem #(
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter int unsigned SIZ = 1024,
    parameter int unsigned DLY = 1,
    parameter bit          HLD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tcb_vld,
    output logic             tcb_rdy,
    input  logic             tcb_req_wen,
    input  logic [ADR-1:0]   tcb_req_adr,
    input  logic [DAT/8-1:0] tcb_req_byt,
    input  logic [DAT-1:0]   tcb_req_wdt,
    output logic [DAT-1:0]   tcb_rsp_rdt,
    output logic             tcb_rsp_sts
);

    localparam int unsigned BYT = DAT / 8;
    localparam int unsigned WRD = SIZ / BYT;
    localparam int unsigned ABW = $clog2(SIZ);
    localparam int unsigned BBW = $clog2(BYT);
    localparam int unsigned IBW = (ABW > BBW) ? (ABW - BBW) : 1;

    logic             r_rdy;
    logic [DAT-1:0]   r_mem [WRD];

    logic             r_vld [DLY];
    logic [DAT-1:0]   r_rdt [DLY];
    logic             r_sts [DLY];

    logic [DAT-1:0]   r_holdRdt;
    logic             r_holdSts;

    logic             w_trn;
    logic             w_oob;
    logic             w_mis;
    logic             w_err;
    logic [IBW-1:0]   w_idx;
    logic [DAT-1:0]   w_rdData;

    // A transfer only happens once ready is up, so requests presented during
    // reset or on the first cycle after release are silently ignored.
    assign w_trn = tcb_vld & r_rdy;

    // Any address bit at or above log2(SIZ) means out of range; there is no
    // aliasing. Low address bits inside a word mean a misaligned access.
    assign w_oob = |(tcb_req_adr >> ABW);
    assign w_mis = |(tcb_req_adr & ADR'(BYT - 1));
    assign w_err = w_oob | w_mis;

    assign w_idx    = IBW'(tcb_req_adr >> BBW);
    assign w_rdData = r_mem[w_idx];

    assign tcb_rdy = r_rdy;

    // Ready comes up on the first edge after reset release and stays there;
    // this block never applies backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    // Memory array. It has no reset so contents survive a reset pulse, and
    // only enabled bytes of an error-free write transfer are updated.
    always_ff @(posedge clk) begin
        if (w_trn && tcb_req_wen && !w_err) begin
            for (int i = 0; i < BYT; i++) begin
                if (tcb_req_byt[i]) begin
                    r_mem[w_idx][8*i +: 8] <= tcb_req_wdt[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline. Stage 0 captures every edge: a read returns the full
    // word (byte enables ignored), writes and errored accesses return zero
    // data. Later stages simply shift. Reset drops everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DLY; k++) begin
                r_vld[k] <= 1'b0;
                r_rdt[k] <= '0;
                r_sts[k] <= 1'b0;
            end
        end else begin
            r_vld[0] <= w_trn;
            r_rdt[0] <= (w_trn && !tcb_req_wen && !w_err) ? w_rdData : '0;
            r_sts[0] <= w_trn & w_err;
            for (int k = 1; k < DLY; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_rdt[k] <= r_rdt[k-1];
                r_sts[k] <= r_sts[k-1];
            end
        end
    end

    // Copy of the most recent response delivered, used to keep the outputs
    // steady between responses when holding is enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_holdRdt <= '0;
            r_holdSts <= 1'b0;
        end else if (r_vld[DLY-1]) begin
            r_holdRdt <= r_rdt[DLY-1];
            r_holdSts <= r_sts[DLY-1];
        end
    end

    // The last stage drives the outputs directly, so a transfer at edge n is
    // visible right after edge n+DLY-1; idle cycles show the held or zero value.
    assign tcb_rsp_rdt = r_vld[DLY-1] ? r_rdt[DLY-1] : (HLD ? r_holdRdt : '0);
    assign tcb_rsp_sts = r_vld[DLY-1] ? r_sts[DLY-1] : (HLD ? r_holdSts : 1'b0);

endmodule

// File: tb/tb_tcb_sub_mem.sv
// ---------------------------------------------------------------------------
// tb_tcb_sub_mem
// Bench for tcb_sub_mem. Four instances share one clock, each with its own
// request/reset signals:
//   dut 0 : DLY=1, HLD=1  reset, full/partial writes, errors, boundaries
//   dut 1 : DLY=2, HLD=0  back-to-back reads
//   dut 2 : DLY=3, HLD=1  output hold over idle cycles
//   dut 3 : DLY=3, HLD=0  reset while responses are in flight
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_tcb_sub_mem;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst    [NDUT];
    logic        vld    [NDUT];
    logic        rdy    [NDUT];
    logic        wen    [NDUT];
    logic [31:0] adr    [NDUT];
    logic [3:0]  byt    [NDUT];
    logic [31:0] wdt    [NDUT];
    logic [31:0] rdt    [NDUT];
    logic        sts    [NDUT];

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        int          dut;
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] expRdt;
        logic        expSts;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    tcb_sub_mem #(.ADR(32), .DAT(32), .SIZ(1024), .DLY(1), .HLD(1'b1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .tcb_vld(vld[0]), .tcb_rdy(rdy[0]),
        .tcb_req_wen(wen[0]), .tcb_req_adr(adr[0]), .tcb_req_byt(byt[0]),
        .tcb_req_wdt(wdt[0]), .tcb_rsp_rdt(rdt[0]), .tcb_rsp_sts(sts[0])
    );

    tcb_sub_mem #(.ADR(32), .DAT(32), .SIZ(1024), .DLY(2), .HLD(1'b0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .tcb_vld(vld[1]), .tcb_rdy(rdy[1]),
        .tcb_req_wen(wen[1]), .tcb_req_adr(adr[1]), .tcb_req_byt(byt[1]),
        .tcb_req_wdt(wdt[1]), .tcb_rsp_rdt(rdt[1]), .tcb_rsp_sts(sts[1])
    );

    tcb_sub_mem #(.ADR(32), .DAT(32), .SIZ(1024), .DLY(3), .HLD(1'b1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .tcb_vld(vld[2]), .tcb_rdy(rdy[2]),
        .tcb_req_wen(wen[2]), .tcb_req_adr(adr[2]), .tcb_req_byt(byt[2]),
        .tcb_req_wdt(wdt[2]), .tcb_rsp_rdt(rdt[2]), .tcb_rsp_sts(sts[2])
    );

    tcb_sub_mem #(.ADR(32), .DAT(32), .SIZ(1024), .DLY(3), .HLD(1'b0)) u_dut3 (
        .clk(clk), .rst(rst[3]), .tcb_vld(vld[3]), .tcb_rdy(rdy[3]),
        .tcb_req_wen(wen[3]), .tcb_req_adr(adr[3]), .tcb_req_byt(byt[3]),
        .tcb_req_wdt(wdt[3]), .tcb_rsp_rdt(rdt[3]), .tcb_rsp_sts(sts[3])
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Compares read data, status and ready of one instance.
    task automatic checkOutput(input int d, input string name, input logic [31:0] expRdt,
                               input logic expSts, input logic expRdy);
        checkVal({name, ".rdt"}, rdt[d], expRdt);
        checkVal({name, ".sts"}, {31'd0, sts[d]}, {31'd0, expSts});
        checkVal({name, ".rdy"}, {31'd0, rdy[d]}, {31'd0, expRdy});
    endtask

    // Drops the request lines of every instance.
    task automatic idleAll();
        for (int i = 0; i < NDUT; i++) begin
            vld[i] = 1'b0;
            wen[i] = 1'b0;
            adr[i] = 32'h0;
            byt[i] = 4'h0;
            wdt[i] = 32'h0;
        end
    endtask

    // Presents one request on instance d, all others idle.
    task automatic drive(input int d, input logic v, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] dt);
        idleAll();
        vld[d] = v;
        wen[d] = w;
        adr[d] = a;
        byt[d] = b;
        wdt[d] = dt;
    endtask

    // One clock: through the rising edge, then to the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Applies one table vector and checks the outputs after its edge.
    task automatic applyStimulus(input vec_t vc);
        drive(vc.dut, vc.v, vc.w, vc.a, vc.b, vc.d);
        tick();
        checkOutput(vc.dut, vc.name, vc.expRdt, vc.expSts, 1'b1);
    endtask

    task automatic addVec(input int d, input logic v, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] dt,
                          input logic [31:0] er, input logic es, input string nm);
        vec_t vc;
        vc.dut = d; vc.v = v; vc.w = w; vc.a = a; vc.b = b; vc.d = dt;
        vc.expRdt = er; vc.expSts = es; vc.name = nm;
        vecs.push_back(vc);
    endtask

    initial begin
        // Expected value of each vector is the response visible after its edge:
        // for dut 0 (DLY=1) that is the vector's own response; for dut 1
        // (DLY=2) it is the response of the preceding vector.
        addVec(0, 1, 1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0,        0, "wrFull");
        addVec(0, 1, 0, 32'h10,  4'hF, 32'h0,        32'hDEADBEEF, 0, "rdFull");
        addVec(0, 1, 1, 32'h10,  4'h2, 32'h0000AA00, 32'h0,        0, "wrPart");
        addVec(0, 1, 0, 32'h10,  4'h0, 32'h0,        32'hDEADAAEF, 0, "rdPart");
        addVec(0, 1, 0, 32'h400, 4'h0, 32'h0,        32'h0,        1, "rdOob");
        addVec(0, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1, "idleHoldErr");
        addVec(0, 1, 1, 32'h13,  4'hF, 32'hFFFFFFFF, 32'h0,        1, "wrMisaligned");
        addVec(0, 1, 0, 32'h10,  4'hF, 32'h0,        32'hDEADAAEF, 0, "rdAfterErr");
        addVec(0, 0, 0, 32'h0,   4'h0, 32'h0,        32'hDEADAAEF, 0, "idleHoldData");
        addVec(0, 1, 0, 32'h11,  4'hF, 32'h0,        32'h0,        1, "rdMisaligned");
        addVec(0, 1, 1, 32'h3FC, 4'hF, 32'hCAFEF00D, 32'h0,        0, "wrLastWord");
        addVec(0, 1, 0, 32'h3FC, 4'hF, 32'h0,        32'hCAFEF00D, 0, "rdLastWord");
        addVec(0, 1, 0, 32'h10000010, 4'hF, 32'h0,   32'h0,        1, "rdNoAlias");
        addVec(0, 1, 1, 32'h10,  4'h0, 32'h12345678, 32'h0,        0, "wrNoBytes");
        addVec(0, 1, 0, 32'h10,  4'hF, 32'h0,        32'hDEADAAEF, 0, "rdNoBytes");

        addVec(1, 1, 1, 32'h0,   4'hF, 32'h1,        32'h0,        0, "b2bPre0");
        addVec(1, 1, 1, 32'h4,   4'hF, 32'h2,        32'h0,        0, "b2bPre4");
        addVec(1, 1, 1, 32'h8,   4'hF, 32'h3,        32'h0,        0, "b2bPre8");
        addVec(1, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        0, "b2bGap0");
        addVec(1, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        0, "b2bGap1");
        addVec(1, 1, 0, 32'h0,   4'hF, 32'h0,        32'h0,        0, "b2bRd0");
        addVec(1, 1, 0, 32'h4,   4'hF, 32'h0,        32'h1,        0, "b2bRd4");
        addVec(1, 1, 0, 32'h8,   4'hF, 32'h0,        32'h2,        0, "b2bRd8");
        addVec(1, 0, 0, 32'h0,   4'h0, 32'h0,        32'h3,        0, "b2bTail0");
        addVec(1, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        0, "b2bTail1");

        // Reset with a read request held on dut 0: nothing may be accepted.
        idleAll();
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;
        vld[0] = 1'b1;
        adr[0] = 32'h10;
        byt[0] = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput(0, "inReset", 32'h0, 1'b0, 1'b0);
        end
        checkOutput(3, "inReset3", 32'h0, 1'b0, 1'b0);

        // Request still held across release: ready rises, but that edge
        // carries no transfer so no response slot appears.
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b1;
        tick();
        checkOutput(0, "release", 32'h0, 1'b0, 1'b1);
        idleAll();
        tick();
        checkOutput(0, "releaseNoRsp", 32'h0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // DLY=3, HLD=1: read response shows three cycles after its transfer
        // and stays on the outputs through idle cycles.
        drive(2, 1, 1, 32'h20, 4'hF, 32'h00001234);
        tick();
        checkOutput(2, "hldWr", 32'h0, 1'b0, 1'b1);
        drive(2, 1, 0, 32'h20, 4'hF, 32'h0);
        tick();
        checkOutput(2, "hldRd", 32'h0, 1'b0, 1'b1);
        idleAll();
        tick();
        checkOutput(2, "hldWrRsp", 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput(2, "hldRdRsp", 32'h00001234, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput(2, "hldIdle", 32'h00001234, 1'b0, 1'b1);
        end

        // DLY=3, HLD=0: write then two reads, reset pulse while both reads
        // are in flight; neither may surface, the written word must survive.
        drive(3, 1, 1, 32'h40, 4'hF, 32'h55AA55AA);
        tick();
        checkOutput(3, "midWr", 32'h0, 1'b0, 1'b1);
        drive(3, 1, 0, 32'h40, 4'hF, 32'h0);
        tick();
        checkOutput(3, "midRd0", 32'h0, 1'b0, 1'b1);
        drive(3, 1, 0, 32'h40, 4'hF, 32'h0);
        tick();
        checkOutput(3, "midRd1", 32'h0, 1'b0, 1'b1);
        idleAll();
        rst[3] = 1'b0;
        tick();
        checkOutput(3, "midInRst", 32'h0, 1'b0, 1'b0);
        rst[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput(3, "midNoStale", 32'h0, 1'b0, 1'b1);
        end
        drive(3, 1, 0, 32'h40, 4'hF, 32'h0);
        tick();
        checkOutput(3, "persistRd", 32'h0, 1'b0, 1'b1);
        idleAll();
        tick();
        checkOutput(3, "persistWait", 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput(3, "persistRsp", 32'h55AA55AA, 1'b0, 1'b1);
        tick();
        checkOutput(3, "persistAfter", 32'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
